// File: rtl/apb_pkg.sv
// apb_pkg
// Shared definitions for the APB master slice: the transfer FSM state type,
// the slave count, the address map of the slave region and the wait-state
// timeout limit.
package apb_pkg;

  // Transfer phases of the APB master
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Number of slaves behind the master and the width of a slave index
  localparam int SLAVE_COUNT = 4;
  localparam int SLAVE_IDX_W = $clog2(SLAVE_COUNT);

  // Slave region: SLAVE_COUNT consecutive 4 KiB windows starting at REGION_BASE
  localparam logic [31:0] REGION_BASE   = 32'h1000_0000;
  localparam int          REGION_STRIDE = 4096;
  localparam int          STRIDE_LOG2   = $clog2(REGION_STRIDE);
  localparam int          REGION_LSB    = STRIDE_LOG2 + SLAVE_IDX_W;

  // Wait counter width and the count at which an access is abandoned
  localparam int                WAIT_W        = 4;
  localparam logic [WAIT_W-1:0] TIMEOUT_LIMIT = 4'd15;

endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder
// Combinational address decoder and read-return multiplexer.
// Ports:
//   addr       in   registered APB address
//   prdata     in   read data of every slave, indexed by slave number
//   pready     in   ready of every slave, indexed by slave number
//   sel        out  one-hot slave select (all zero on a miss)
//   miss       out  address lies outside the slave region
//   sel_prdata out  read data of the selected slave (zero on a miss)
//   sel_pready out  ready of the selected slave (zero on a miss)
module apb_addr_decoder
  import apb_pkg::*;
(
  input  logic [31:0]                  addr,
  input  logic [SLAVE_COUNT-1:0][31:0] prdata,
  input  logic [SLAVE_COUNT-1:0]       pready,
  output logic [SLAVE_COUNT-1:0]       sel,
  output logic                         miss,
  output logic [31:0]                  sel_prdata,
  output logic                         sel_pready
);

  logic                   hit;
  logic [SLAVE_IDX_W-1:0] idx;
  logic                   unused_offset;

  // The byte offset within a 4 KiB window plays no part in slave selection
  assign unused_offset = ^addr[STRIDE_LOG2-1:0];

  // The upper address bits must match the region base; the two bits just
  // above the window offset pick the slave. Unselected slaves never reach
  // the return path, so their PREADY/PRDATA cannot influence a transfer.
  always_comb begin
    hit        = (addr[31:REGION_LSB] == REGION_BASE[31:REGION_LSB]);
    idx        = addr[REGION_LSB-1:STRIDE_LOG2];
    sel        = '0;
    sel_prdata = '0;
    sel_pready = 1'b0;
    miss       = ~hit;
    if (hit) begin
      sel[idx]   = 1'b1;
      sel_prdata = prdata[idx];
      sel_pready = pready[idx];
    end
  end

endmodule

// File: rtl/apb_master.sv
// apb_master
// Single-outstanding APB master bridging a simple CPU request strobe onto
// four APB slaves.
// Ports:
//   PCLK, PRESET            clock and synchronous active-high reset
//   transfer/write/addr/wdata  CPU request, accepted only in IDLE
//   ready/rdata/err         one-cycle completion pulse with read data and error
//   PADDR/PWDATA/PWRITE     APB address, write data and direction
//   PENABLE                 APB access phase
//   PSEL0..PSEL3            one-hot slave selects
//   PRDATA0..PRDATA3        slave read data
//   PREADY0..PREADY3        slave ready
module apb_master
  import apb_pkg::*;
(
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PENABLE,
  output logic        PSEL0,
  output logic        PSEL1,
  output logic        PSEL2,
  output logic        PSEL3,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic        PREADY0,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic        PREADY3
);

  apb_state_e                   state;
  logic [WAIT_W-1:0]            wait_cnt;
  logic [SLAVE_COUNT-1:0][31:0] prdata_bus;
  logic [SLAVE_COUNT-1:0]       pready_bus;
  logic [SLAVE_COUNT-1:0]       sel;
  logic                         miss;
  logic [31:0]                  sel_prdata;
  logic                         sel_pready;
  logic                         psel_active;

  assign prdata_bus = {PRDATA3, PRDATA2, PRDATA1, PRDATA0};
  assign pready_bus = {PREADY3, PREADY2, PREADY1, PREADY0};

  // Decode always works on the registered PADDR, so selects are stable for
  // the whole of SETUP and ACCESS.
  apb_addr_decoder u_decoder (
    .addr       (PADDR),
    .prdata     (prdata_bus),
    .pready     (pready_bus),
    .sel        (sel),
    .miss       (miss),
    .sel_prdata (sel_prdata),
    .sel_pready (sel_pready)
  );

  // Selects are a pure function of two registers: the FSM state and the
  // latched address. Nothing is selected in IDLE or on a decode miss.
  assign psel_active = (state != ST_IDLE);
  assign PSEL0 = psel_active & sel[0];
  assign PSEL1 = psel_active & sel[1];
  assign PSEL2 = psel_active & sel[2];
  assign PSEL3 = psel_active & sel[3];

  // Transfer FSM. ready and err default low so every completion is a single
  // cycle pulse; the cycle after completion is IDLE, which lets a new request
  // be taken while ready is high. A selected PREADY on the same edge the wait
  // counter would time out wins, because the slave did answer in time.
  // rdata is only rewritten on completion and otherwise holds.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      PADDR    <= '0;
      PWDATA   <= '0;
      PWRITE   <= 1'b0;
      PENABLE  <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (transfer) begin
            PADDR  <= addr;
            PWDATA <= wdata;
            PWRITE <= write;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (miss) begin
            ready   <= 1'b1;
            err     <= 1'b1;
            rdata   <= '0;
            PENABLE <= 1'b0;
            state   <= ST_IDLE;
          end else if (sel_pready) begin
            ready   <= 1'b1;
            err     <= 1'b0;
            rdata   <= PWRITE ? 32'h0 : sel_prdata;
            PENABLE <= 1'b0;
            state   <= ST_IDLE;
          end else if (wait_cnt == TIMEOUT_LIMIT - 4'd1) begin
            wait_cnt <= wait_cnt + 4'd1;
            ready    <= 1'b1;
            err      <= 1'b1;
            rdata    <= '0;
            PENABLE  <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: begin
          PENABLE <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master
// Directed bench for apb_master: a table of single transfers with a scripted
// slave response, followed by back-to-back and reset-during-access sequences.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        transfer;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PENABLE;
  logic        PSEL0, PSEL1, PSEL2, PSEL3;
  logic [31:0] prdata_tb [4];
  logic [3:0]  pready_tb;

  int tests_run = 0;
  int tests_failed = 0;

  // One directed transfer: request, scripted slave, and hand-computed result.
  // slave = -1 means no slave answers; wait_cycles = 99 means never ready.
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          slave;
    int          wait_cycles;
    logic [31:0] prdata;
    logic [3:0]  noise;
    logic [3:0]  exp_psel;
    int          exp_ready_cycle;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  // Observations gathered by applyStimulus
  int          ready_cycle;
  int          ready_count;
  int          onehot_bad;
  logic [3:0]  psel_c1;
  logic [3:0]  psel_last_access;
  logic [3:0]  psel_ready;
  logic        pen_c1;
  logic        pen_c2;
  logic [31:0] rdata_r;
  logic        err_r;
  logic [31:0] paddr_c1;
  logic [31:0] pwdata_c1;
  logic        pwrite_c1;

  // Per-cycle records for the hand-written sequences
  logic        rdy_k   [32];
  logic [3:0]  psel_k  [32];
  logic        pen_k   [32];
  logic [31:0] rdata_k [32];

  apb_master dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .transfer (transfer),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .rdata    (rdata),
    .err      (err),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PENABLE  (PENABLE),
    .PSEL0    (PSEL0),
    .PSEL1    (PSEL1),
    .PSEL2    (PSEL2),
    .PSEL3    (PSEL3),
    .PRDATA0  (prdata_tb[0]),
    .PRDATA1  (prdata_tb[1]),
    .PRDATA2  (prdata_tb[2]),
    .PRDATA3  (prdata_tb[3]),
    .PREADY0  (pready_tb[0]),
    .PREADY1  (pready_tb[1]),
    .PREADY2  (pready_tb[2]),
    .PREADY3  (pready_tb[3])
  );

  // 10 ns clock
  always #5 PCLK = ~PCLK;

  // Hard bound on simulation time in case the DUT wedges the bench
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] psel_now();
    return {PSEL3, PSEL2, PSEL1, PSEL0};
  endfunction

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one transfer (edge 0 samples it), script the slave, and record
  // what the DUT shows in cycles 1..20 after the request edge
  task automatic applyStimulus(input vec_t v);
    logic [3:0] p;
    @(negedge PCLK);
    transfer = 1'b1;
    write    = v.write;
    addr     = v.addr;
    wdata    = v.wdata;
    for (int s = 0; s < 4; s++) prdata_tb[s] = 32'hBAD0_0000 | 32'(s);
    if (v.slave >= 0) prdata_tb[v.slave] = v.prdata;
    pready_tb = v.noise;
    ready_cycle      = 0;
    ready_count      = 0;
    onehot_bad       = 0;
    psel_last_access = 4'h0;
    psel_ready       = 4'hF;
    rdata_r          = 32'hFFFF_FFFF;
    err_r            = 1'bx;
    @(posedge PCLK);
    for (int k = 1; k <= 20; k++) begin
      @(negedge PCLK);
      transfer  = 1'b0;
      pready_tb = v.noise;
      if (v.slave >= 0 && k >= 2 + v.wait_cycles) pready_tb[v.slave] = 1'b1;
      p = psel_now();
      if ($countones(p) > 1) onehot_bad++;
      if (k == 1) begin
        psel_c1   = p;
        pen_c1    = PENABLE;
        paddr_c1  = PADDR;
        pwdata_c1 = PWDATA;
        pwrite_c1 = PWRITE;
      end
      if (k == 2) pen_c2 = PENABLE;
      if (ready) begin
        ready_count++;
        if (ready_cycle == 0) begin
          ready_cycle = k;
          rdata_r     = rdata;
          err_r       = err;
          psel_ready  = p;
        end
      end
      if (ready_cycle == 0) psel_last_access = p;
    end
    pready_tb = 4'h0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h1000_2000, 32'h0000_00FF, 2, 1,  32'hCAFE_0002, 4'b0000, 4'b0100, 4,  32'h0,         1'b0};
    vecs[1] = '{1'b0, 32'h1000_1004, 32'h0,         1, 0,  32'h0000_005A, 4'b0000, 4'b0010, 3,  32'h0000_005A, 1'b0};
    vecs[2] = '{1'b0, 32'h2000_0000, 32'h0,        -1, 0,  32'h0,         4'b1111, 4'b0000, 3,  32'h0,         1'b1};
    vecs[3] = '{1'b0, 32'h1000_3000, 32'h0,         3, 99, 32'h3333_3333, 4'b0000, 4'b1000, 17, 32'h0,         1'b1};
    vecs[4] = '{1'b0, 32'h1000_0FFC, 32'h0,         0, 2,  32'hDEAD_BEEF, 4'b1110, 4'b0001, 5,  32'hDEAD_BEEF, 1'b0};
    vecs[5] = '{1'b1, 32'h1000_3ABC, 32'h1234_5678, 3, 0,  32'h7777_7777, 4'b0111, 4'b1000, 3,  32'h0,         1'b0};
    vecs[6] = '{1'b0, 32'h1000_4000, 32'h0,        -1, 0,  32'h0,         4'b0000, 4'b0000, 3,  32'h0,         1'b1};
    vecs[7] = '{1'b0, 32'h0FFF_FFFC, 32'h0,        -1, 0,  32'h0,         4'b0000, 4'b0000, 3,  32'h0,         1'b1};
    vecs[8] = '{1'b0, 32'h1000_2FFF, 32'h0,         2, 14, 32'hA5A5_A5A5, 4'b0000, 4'b0100, 17, 32'hA5A5_A5A5, 1'b0};
    vecs[9] = '{1'b0, 32'h1000_1000, 32'h0,         1, 13, 32'h0F0F_0F0F, 4'b0000, 4'b0010, 16, 32'h0F0F_0F0F, 1'b0};

    // Reset with a request pending: reset must dominate
    PRESET    = 1'b1;
    transfer  = 1'b1;
    write     = 1'b1;
    addr      = 32'h1000_2000;
    wdata     = 32'h5555_5555;
    pready_tb = 4'hF;
    for (int s = 0; s < 4; s++) prdata_tb[s] = 32'hFFFF_FFFF;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    checkOutput("reset ready",   32'(ready),      32'h0);
    checkOutput("reset err",     32'(err),        32'h0);
    checkOutput("reset rdata",   rdata,           32'h0);
    checkOutput("reset PADDR",   PADDR,           32'h0);
    checkOutput("reset PWDATA",  PWDATA,          32'h0);
    checkOutput("reset PWRITE",  32'(PWRITE),     32'h0);
    checkOutput("reset PENABLE", 32'(PENABLE),    32'h0);
    checkOutput("reset PSEL",    32'(psel_now()), 32'h0);
    transfer  = 1'b0;
    pready_tb = 4'h0;
    PRESET    = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    checkOutput("post-reset PSEL", 32'(psel_now()), 32'h0);

    // Table of single transfers
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d ready_cycle", i),   32'(ready_cycle),      32'(vecs[i].exp_ready_cycle));
      checkOutput($sformatf("v%0d ready_count", i),   32'(ready_count),      32'd1);
      checkOutput($sformatf("v%0d rdata", i),         rdata_r,               vecs[i].exp_rdata);
      checkOutput($sformatf("v%0d err", i),           32'(err_r),            32'(vecs[i].exp_err));
      checkOutput($sformatf("v%0d psel_setup", i),    32'(psel_c1),          32'(vecs[i].exp_psel));
      checkOutput($sformatf("v%0d psel_access", i),   32'(psel_last_access), 32'(vecs[i].exp_psel));
      checkOutput($sformatf("v%0d psel_ready", i),    32'(psel_ready),       32'h0);
      checkOutput($sformatf("v%0d penable_setup", i), 32'(pen_c1),           32'h0);
      checkOutput($sformatf("v%0d penable_access", i),32'(pen_c2),           32'h1);
      checkOutput($sformatf("v%0d onehot", i),        32'(onehot_bad),       32'h0);
      checkOutput($sformatf("v%0d PADDR", i),         paddr_c1,              vecs[i].addr);
      checkOutput($sformatf("v%0d PWDATA", i),        pwdata_c1,             vecs[i].wdata);
      checkOutput($sformatf("v%0d PWRITE", i),        32'(pwrite_c1),        32'(vecs[i].write));
    end

    // Back-to-back: slave 1 read with PREADY1 held high throughout, second
    // read to slave 0 raised in the ready cycle (cycle 3). PREADY0 is also
    // pulsed during the second SETUP (cycle 4) and must be ignored there.
    @(negedge PCLK);
    transfer     = 1'b1;
    write        = 1'b0;
    addr         = 32'h1000_1000;
    prdata_tb[0] = 32'h0000_0022;
    prdata_tb[1] = 32'h0000_0011;
    pready_tb    = 4'b0010;
    @(posedge PCLK);
    for (int k = 1; k <= 9; k++) begin
      @(negedge PCLK);
      transfer = (k == 3);
      if (k == 3) addr = 32'h1000_0010;
      pready_tb = {2'b00, 1'b1, (k == 4 || k >= 6)};
      rdy_k[k]   = ready;
      psel_k[k]  = psel_now();
      pen_k[k]   = PENABLE;
      rdata_k[k] = rdata;
    end
    pready_tb = 4'h0;
    checkOutput("b2b first ready",    32'(rdy_k[3]),  32'h1);
    checkOutput("b2b first rdata",    rdata_k[3],     32'h0000_0011);
    checkOutput("b2b idle psel",      32'(psel_k[3]), 32'h0);
    checkOutput("b2b setup psel",     32'(psel_k[4]), 32'b0001);
    checkOutput("b2b setup penable",  32'(pen_k[4]),  32'h0);
    checkOutput("b2b ready c4",       32'(rdy_k[4]),  32'h0);
    checkOutput("b2b access penable", 32'(pen_k[5]),  32'h1);
    checkOutput("b2b ready c5",       32'(rdy_k[5]),  32'h0);
    checkOutput("b2b ready c6",       32'(rdy_k[6]),  32'h0);
    checkOutput("b2b second ready",   32'(rdy_k[7]),  32'h1);
    checkOutput("b2b second rdata",   rdata_k[7],     32'h0000_0022);
    checkOutput("b2b ready c8",       32'(rdy_k[8]),  32'h0);

    // Reset during ACCESS of a write to slave 2 that never answers; after
    // reset, PREADY2 rises and must not produce a completion
    @(negedge PCLK);
    transfer     = 1'b1;
    write        = 1'b1;
    addr         = 32'h1000_2000;
    wdata        = 32'h9999_0000;
    prdata_tb[2] = 32'h0000_00AA;
    pready_tb    = 4'h0;
    @(posedge PCLK);
    ready_count = 0;
    onehot_bad  = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge PCLK);
      transfer = 1'b0;
      PRESET   = (k == 3);
      if (k >= 4) pready_tb = 4'b0100;
      if (k == 3) pen_c2 = PENABLE;
      if (k == 4) begin
        psel_k[4]  = psel_now();
        pen_k[4]   = PENABLE;
        rdy_k[4]   = ready;
        paddr_c1   = PADDR;
        pwdata_c1  = PWDATA;
      end
      if (k >= 4 && (ready || psel_now() != 4'h0)) onehot_bad++;
      if (ready) ready_count++;
    end
    PRESET    = 1'b0;
    pready_tb = 4'h0;
    checkOutput("rst access penable",   32'(pen_c2),    32'h1);
    checkOutput("rst next psel",        32'(psel_k[4]), 32'h0);
    checkOutput("rst next penable",     32'(pen_k[4]),  32'h0);
    checkOutput("rst next ready",       32'(rdy_k[4]),  32'h0);
    checkOutput("rst next PADDR",       paddr_c1,       32'h0);
    checkOutput("rst next PWDATA",      pwdata_c1,      32'h0);
    checkOutput("rst no ready pulse",   32'(ready_count), 32'h0);
    checkOutput("rst idle afterwards",  32'(onehot_bad),  32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
